multicycle_subtractor: RTL and testbench

//   Chunk-serial subtractor: d = a - b - bin over BITS/CHUNK cycles, carrying the

---
 rtl/multicycle_subtractor.sv | 130 +++++++++++++
 tb/tb_multicycle_subtractor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_subtractor.sv
// multicycle_subtractor
//   Chunk-serial subtractor computing d = a - b - bin over BITS/CHUNK cycles, with the
//   borrow carried between chunks in a register. Valid/ready handshake on both sides;
//   result flags (bout, zero, ovf) are produced alongside the difference.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operands present
//   in_ready   block can accept an operation (high only in idle)
//   a, b, bin  minuend, subtrahend, borrow in (captured at accept)
//   out_valid  result held on d/bout/zero/ovf
//   out_ready  consumer takes result
//   d          difference modulo 2^BITS
//   bout       borrow out: 1 iff a < b + bin (unsigned)
//   zero       d == 0
//   ovf        signed overflow of a - b - bin

module multicycle_subtractor #(
    parameter int unsigned BITS  = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] d,
    output logic            bout,
    output logic            zero,
    output logic            ovf
);

    localparam int unsigned N    = BITS / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef logic [IdxW-1:0] idx_t;
    localparam idx_t LastIdx = idx_t'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;
    logic            borrow_q;
    idx_t            idx_q;
    logic [BITS-1:0] d_q;
    logic            bout_q;
    logic            zero_q;
    logic            ovf_q;
    logic            out_valid_q;

    logic [31:0]     base_bit;
    logic [CHUNK:0]  chunk_sum;
    logic            chunk_borrow;
    logic [BITS-1:0] d_next;

    // Subtraction as a + ~b + carry_in, where carry_in is the inverted running borrow.
    always_comb begin
        base_bit     = 32'(idx_q) * CHUNK;
        chunk_sum    = {1'b0, a_q[base_bit +: CHUNK]}
                     + {1'b0, ~b_q[base_bit +: CHUNK]}
                     + {{CHUNK{1'b0}}, ~borrow_q};
        chunk_borrow = ~chunk_sum[CHUNK];
        d_next       = d_q;
        d_next[base_bit +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            idx_q       <= '0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        idx_q    <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    d_q      <= d_next;
                    borrow_q <= chunk_borrow;
                    if (idx_q == LastIdx) begin
                        // Flags use the full result including the chunk written this cycle.
                        idx_q       <= '0;
                        bout_q      <= chunk_borrow;
                        zero_q      <= (d_next == '0);
                        ovf_q       <= (a_q[BITS-1] != b_q[BITS-1]) &&
                                       (d_next[BITS-1] != a_q[BITS-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Directed bench for multicycle_subtractor: default 8-bit chunks plus a
// single-chunk (CHUNK=32) instance for the one-cycle RUN case.

module tb_multicycle_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, bin, out_valid, out_ready, bout, zero, ovf;
    logic [31:0] a, b, d;

    logic        w_in_valid, w_in_ready, w_bin, w_out_valid, w_out_ready;
    logic        w_bout, w_zero, w_ovf;
    logic [31:0] w_a, w_b, w_d;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_subtractor #(.BITS(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .zero(zero), .ovf(ovf)
    );

    multicycle_subtractor #(.BITS(32), .CHUNK(32)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .bin(w_bin), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .d(w_d), .bout(w_bout), .zero(w_zero), .ovf(w_ovf)
    );

    // Accept one op, scramble the inputs afterwards, count cycles until out_valid.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                          output int lat);
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_v; bin = tbin;
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; bin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rst_d: got %h want 0", d); end
        vectors++; if ({bout, zero, ovf} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {bout, zero, ovf}); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        run_op(32'd5, 32'd3, 1'b0, lat);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d want 4", lat); end
        vectors++; if (d !== 32'd2) begin miscompares++; $display("FAIL basic_d: got %h want 2", d); end
        vectors++; if ({bout, zero, ovf} !== 3'b000) begin miscompares++; $display("FAIL basic_flags: got %b want 000", {bout, zero, ovf}); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_done: got %b want 0", in_ready); end
        finish_op();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_out_valid_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_borrow_chain();
        int lat;
        run_op(32'h0000_0100, 32'h1, 1'b0, lat);
        vectors++; if (d !== 32'h0000_00FF) begin miscompares++; $display("FAIL chain_d: got %h want 000000ff", d); end
        vectors++; if (bout !== 1'b0) begin miscompares++; $display("FAIL chain_bout: got %b want 0", bout); end
        finish_op();
        run_op(32'h0, 32'h1, 1'b0, lat);
        vectors++; if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_d: got %h want ffffffff", d); end
        vectors++; if ({bout, zero, ovf} !== 3'b100) begin miscompares++; $display("FAIL wrap_flags: got %b want 100", {bout, zero, ovf}); end
        finish_op();
    endtask

    task automatic test_overflow_zero();
        int lat;
        run_op(32'h8000_0000, 32'h1, 1'b0, lat);
        vectors++; if (d !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL ovf_d: got %h want 7fffffff", d); end
        vectors++; if ({bout, zero, ovf} !== 3'b001) begin miscompares++; $display("FAIL ovf_flags: got %b want 001", {bout, zero, ovf}); end
        finish_op();
        run_op(32'd7, 32'd6, 1'b1, lat);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL zero_d: got %h want 0", d); end
        vectors++; if ({bout, zero, ovf} !== 3'b010) begin miscompares++; $display("FAIL zero_flags: got %b want 010", {bout, zero, ovf}); end
        finish_op();
    endtask

    task automatic test_hold();
        int lat;
        run_op(32'd10, 32'd20, 1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'd100 + i; b = 32'd1; bin = 1'b0;
            @(negedge clk);
            vectors++; if ({out_valid, in_ready} !== 2'b10) begin miscompares++; $display("FAIL hold_hs_%0d: got %b want 10", i, {out_valid, in_ready}); end
            vectors++; if ({d, bout, zero, ovf} !== {32'hFFFF_FFF6, 3'b100}) begin miscompares++; $display("FAIL hold_res_%0d: got %h/%b want fffffff6/100", i, d, {bout, zero, ovf}); end
        end
        in_valid = 1'b0;
        finish_op();
        @(negedge clk);
        vectors++; if ({out_valid, in_ready} !== 2'b01) begin miscompares++; $display("FAIL hold_after_hs: got %b want 01", {out_valid, in_ready}); end
        vectors++; if (d !== 32'hFFFF_FFF6) begin miscompares++; $display("FAIL hold_retain_d: got %h want fffffff6", d); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        @(negedge clk);
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0; bin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (d[15:0] !== 16'hFFFF) begin miscompares++; $display("FAIL midrun_partial: got %h want ffff", d[15:0]); end
        rst = 1'b1;
        #1;
        vectors++; if ({out_valid, d} !== 33'h0) begin miscompares++; $display("FAIL midrun_rst: got %b/%h want 0/0", out_valid, d); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrun_discard: got %0d valid cycles want 0", seen); end
        run_op(32'd9, 32'd4, 1'b0, lat);
        vectors++; if ({d, bout, zero, ovf} !== {32'd5, 3'b000}) begin miscompares++; $display("FAIL midrun_next: got %h/%b want 5/000", d, {bout, zero, ovf}); end
        finish_op();
    endtask

    task automatic test_single_chunk();
        int lat;
        @(negedge clk);
        w_in_valid = 1'b1; w_a = 32'h1234_5678; w_b = 32'h1234_5679; w_bin = 1'b0;
        @(negedge clk);
        w_in_valid = 1'b0; w_a = 32'h0; w_b = 32'h0;
        lat = 0;
        while (!w_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL wide_latency: got %0d want 1", lat); end
        vectors++; if (w_d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wide_d: got %h want ffffffff", w_d); end
        vectors++; if ({w_bout, w_zero, w_ovf} !== 3'b100) begin miscompares++; $display("FAIL wide_flags: got %b want 100", {w_bout, w_zero, w_ovf}); end
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        vectors++; if ({w_out_valid, w_in_ready} !== 2'b01) begin miscompares++; $display("FAIL wide_hs: got %b want 01", {w_out_valid, w_in_ready}); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_bin = 1'b0; w_out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_basic();
        test_borrow_chain();
        test_overflow_zero();
        test_hold();
        test_reset_mid_run();
        test_single_chunk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
